// File: rtl/seq_det_pkg.sv
// ---- seq_det_pkg: shared constants and length helpers for seq_det_param ----
`default_nettype none
package seq_det_pkg;

  localparam int MAX_LEN_DEF = 8;
  localparam int LEN_W_DEF   = 4;
  localparam int CNT_W_DEF   = 8;

  function automatic int clamp_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

  // Low 'len' bits set; valid for len up to 31.
  function automatic logic [31:0] pattern_mask(input int len);
    return (32'd1 << len) - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_det_hist.sv
// ---- seq_det_hist: serial history shift register and saturating fill counter ----
`default_nettype none
module seq_det_hist
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               advance,
  input  logic               restart,
  input  logic               bit_in,
  output logic [MAX_LEN-1:0] hist_next,
  output logic [LEN_W-1:0]   fill_next
);

  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;

  // Post-shift view, so the compare sees the bit arriving on this edge.
  always_comb begin
    hist_next = {hist[MAX_LEN-2:0], bit_in};
    fill_next = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hist <= '0;
      fill <= '0;
    end else if (advance) begin
      hist <= hist_next;
      fill <= restart ? '0 : fill_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_det_param.sv
// ---- seq_det_param: programmable serial pattern detector, one-cycle match pulse ----
// ---- Optional saturating match counter enabled by SEQ_DET_MATCH_COUNT_EN ----
`default_nettype none
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in,
  input  logic               in_valid,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               out
`ifdef SEQ_DET_MATCH_COUNT_EN
  ,
  output logic [CNT_W-1:0]   match_count
`endif
);

  if (MAX_LEN < 2 || LEN_W < $clog2(MAX_LEN + 1) || CNT_W < 1) begin : g_param_check
    $error("seq_det_param: illegal MAX_LEN/LEN_W/CNT_W combination");
  end

  logic [MAX_LEN-1:0] cur_pattern;
  logic [LEN_W-1:0]   cur_len;
  logic               cur_overlap;
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_next;
  logic               advance;
  logic               match;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_pattern <= '0;
      cur_len     <= '0;
      cur_overlap <= 1'b1;
    end else if (cfg_we) begin
      cur_pattern <= cfg_pattern;
      cur_len     <= LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
      cur_overlap <= cfg_overlap;
    end
  end

  assign mask    = MAX_LEN'(pattern_mask(int'(cur_len)));
  assign advance = in_valid && !cfg_we;

  // len==0 would make the masked compare trivially true, so it gates detection off.
  assign match = advance && (cur_len != '0) && (fill_next >= cur_len) &&
                 ((hist_next & mask) == (cur_pattern & mask));

  seq_det_hist #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_hist (
    .clk       (clk),
    .rst       (rst),
    .clear     (cfg_we),
    .advance   (advance),
    .restart   (match && !cur_overlap),
    .bit_in    (in),
    .hist_next (hist_next),
    .fill_next (fill_next)
  );

  always_ff @(posedge clk) begin
    if (rst || cfg_we) out <= 1'b0;
    else               out <= match;
  end

`ifdef SEQ_DET_MATCH_COUNT_EN
  // Counts alongside the pulse, so the new value is visible in the pulse cycle.
  always_ff @(posedge clk) begin
    if (rst || cfg_we)                  match_count <= '0;
    else if (match && (match_count != '1)) match_count <= match_count + CNT_W'(1);
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_det_param.sv
// ---- tb_seq_det_param: directed vectors with queued expectations and a decoupled monitor ----
`default_nettype none
module tb_seq_det_param;
  import seq_det_pkg::*;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in = 1'b0;
  logic               in_valid = 1'b0;
  logic               cfg_we = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b1;
  logic               out;
  logic [CNT_W-1:0]   match_count;

  typedef struct {
    logic             out;
    logic [CNT_W-1:0] cnt;
    string            name;
  } exp_t;

  exp_t             q[$];
  exp_t             cur;
  int               checks = 0;
  int               failures = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  always #5 clk = ~clk;

  seq_det_param #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in          (in),
    .in_valid    (in_valid),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .out         (out)
`ifdef SEQ_DET_MATCH_COUNT_EN
    ,
    .match_count (match_count)
`endif
  );

`ifndef SEQ_DET_MATCH_COUNT_EN
  assign match_count = '0;
`endif

  // Inputs change on the falling edge; the expectation describes the next rising edge.
  task automatic step(input logic r, input logic we, input logic v, input logic b,
                      input logic e, input string nm);
    @(negedge clk);
    rst = r; cfg_we = we; in_valid = v; in = b;
    if (r || we)                 exp_cnt = '0;
    else if (e && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    q.push_back('{e, exp_cnt, nm});
  endtask

  task automatic send(input logic [15:0] bits, input logic [15:0] expv, input int n,
                      input string nm);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b0, 1'b1, bits[i], expv[i], nm);
  endtask

  task automatic cfg(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                     input logic ov, input string nm);
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, nm);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      cur = q.pop_front();
      checks++;
      if (out !== cur.out) begin
        failures++;
        $display("FAIL %s out: got %b expected %b at %0t", cur.name, out, cur.out, $time);
      end
`ifdef SEQ_DET_MATCH_COUNT_EN
      checks++;
      if (match_count !== cur.cnt) begin
        failures++;
        $display("FAIL %s match_count: got %0d expected %0d at %0t", cur.name,
                 match_count, cur.cnt, $time);
      end
`endif
    end
  end

  initial begin
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "reset_cfg_disabled");

    cfg(8'b0000_1011, 4'd4, 1'b1, "t1_cfg");
    send(16'b1011011, 16'b0001001, 7, "t1_overlap");

    cfg(8'b0000_1011, 4'd4, 1'b0, "t2_cfg");
    send(16'b1011011, 16'b0001000, 7, "t2_nonoverlap");

    cfg(8'b0000_1011, 4'd4, 1'b1, "t3_cfg");
    send(16'b10, 16'b00, 2, "t3_head");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t3_gap");
    send(16'b11, 16'b01, 2, "t3_tail");

    cfg(8'b0000_1011, 4'd4, 1'b1, "t4_cfg");
    send(16'b101, 16'b000, 3, "t4_partial");
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "t4_rst");
    send(16'b1011, 16'b0000, 4, "t4_after_rst");
    cfg(8'b0000_1011, 4'd4, 1'b1, "t4_recfg");
    send(16'b1011, 16'b0001, 4, "t4_fresh");

    cfg(8'b0000_1011, 4'd4, 1'b1, "t5_cfg");
    send(16'b101, 16'b000, 3, "t5_partial");
    cfg(8'hA5, 4'd8, 1'b1, "t5_cfg_len8");
    send(16'b1010_0101, 16'b0000_0001, 8, "t5_len8");
    cfg(8'hA5, 4'd12, 1'b1, "t5_cfg_len12");
    send(16'b1010_0101, 16'b0000_0001, 8, "t5_clamped");
    cfg(8'h00, 4'd0, 1'b1, "t5_cfg_len0");
    send(16'b0000_1111_0000, 16'b0, 12, "t5_len0");

    cfg(8'b0000_0001, 4'd1, 1'b1, "len1_cfg");
    send(16'b1101, 16'b1101, 4, "len1");

    cfg(8'b0000_1011, 4'd4, 1'b1, "prio_cfg");
    send(16'b101, 16'b000, 3, "prio_head");
    cfg_pattern = 8'b0000_1011; cfg_len = 4'd4; cfg_overlap = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "prio_we_over_valid");
    send(16'b1, 16'b0, 1, "prio_discarded");

`ifdef SEQ_DET_MATCH_COUNT_EN
    cfg(8'b0000_0011, 4'd2, 1'b1, "t6_cfg");
    send(16'b111111, 16'b011111, 6, "t6_count");
    cfg(8'b0000_0011, 4'd2, 1'b1, "t6_clear");
`endif

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #3;
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
